register_scoreboard: RTL
========================

Name: register_scoreboard

Overview:
- Owns and sequences the per-register pending-write state that the forwarding unit consumes as register_invalid.
- Marks destination registers on issue and ages each mark one stage per advancing cycle.
- Honours the forwarding lock, global freeze and branch flush, so forwarding selects and lock decisions stay consistent with pipeline contents.
- Sits in the ID stage beside the forwarding unit and feeds it directly.

Parameters:
- NREG, 8, number of architectural registers; width of rd is $clog2(NREG).
- CW, 3, code width per register (matches the forwarding unit input).
- SCW, 16, width of the saturating stall counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- issue_valid  in  1  an instruction in ID is attempting to advance to EX this cycle.
- issue_we  in  1  that instruction writes a register.
- issue_rd  in  3  its destination register.
- lock  in  1  forwarding lock from the forwarding unit; the ID instruction must not advance.
- freeze  in  1  global pipeline hold (memory wait); no stage advances.
- flush  in  1  branch taken, resolved in EX; squash the EX instruction and the ID instruction.
- register_invalid  out  3 x NREG (unpacked [NREG-1:0])  per-register code: 0 ready in regfile, 1 written in WB this cycle (regfile write-through), 2 value in WB latch, 3 value in EX/MEM latch.
- busy  out  1  OR over registers of (code != 0), combinational from state.
- stall_count  out  SCW  lock-stall cycle count, saturating.

Behaviour:
- Reset (rst_n=0 at posedge):
  - all codes 0, ex_valid 0, ex_rd 0, ex_saved 0, stall_count 0.
  - busy therefore reads 0 the cycle after reset.
- All state is updated at posedge clk only; outputs are registered, except busy.
- freeze=1 has top priority:
  - all state holds, including ex record and stall_count.
  - issue, lock and flush are ignored that cycle.
- Advance cycle (freeze=0), evaluated in this order per register:
  1. Aging: code := code-1 if code != 0, floored at 0.
  2. Flush: if flush && ex_valid, code[ex_rd] := dec(ex_saved). Then ex_valid := 0. Issue is suppressed that cycle.
  3. Issue: if issue_valid && issue_we && !lock && !flush:
     - ex_saved := dec(old code[rd]);
     - code[rd] := 3, overriding steps 1-2;
     - ex_valid := 1, ex_rd := rd.
  4. Otherwise (no issue, no flush): ex_valid := 0, covering bubbles and non-writing instructions.
- Issue with issue_we=0 still clears ex_valid; nothing is marked.
- Re-issue to a pending register: the newest writer overwrites with 3. The older writer's mark is lost by design, since reads need only the newest producer.
- Lock stall (lock=1, freeze=0): aging continues because EX/MEM/WB drain. No mark is made. stall_count += 1 when issue_valid, saturating at 2^SCW-1.
- Flush on the same register as a prior in-flight writer restores that writer's aged code, not 0.
- No illegal state is reachable; codes never exceed 3.

Decomposition:
- Shared package (cpu_pkg):
  - NREG, CW;
  - code constants CODE_READY=0, CODE_WB=1, CODE_MEM=2, CODE_EX=3;
  - typedef reg_idx_t (3 bits) and code_t (3 bits).
- Forwarding unit and scoreboard both import the package.
- One sub-module is natural: scoreboard_cell, a single register's aging/set/restore code register, instantiated NREG times via generate.
- The ex record, flush restore and stall_count stay in the top.

Test Plan:
- Reset then idle: rst_n=0 for one posedge, release -> all codes 0, busy=0, stall_count=0.
- Single writer: issue rd=5 at cycle 0 -> code[5] = 3, 2, 1, 0 on cycles 1-4; busy drops at cycle 4.
- Lock stall: code[2]=3, lock=1 with issue_valid rd=4 for 2 cycles -> code[4] stays 0, code[2] goes 2 then 1, stall_count=2.
- Freeze: code[1]=3, freeze=1 for 3 cycles with issue rd=6 and flush asserted -> code[1]=3, code[6]=0, stall_count and ex record unchanged; aging resumes after release.
- Flush restore: issue rd=3 (code[3]=0 -> 3), issue rd=3 again next cycle, flush next cycle -> code[3]=1 (aged older writer). Concurrent issue rd=7 is not marked.
- Counter saturation: preset SCW=4 and hold lock with issue_valid for 20 cycles -> stall_count stops at 15.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline types: register index, per-register forwarding code and the code values.
package cpu_pkg;
  localparam int NREG = 8;
  localparam int CW   = 3;

  typedef logic [$clog2(NREG)-1:0] reg_idx_t;
  typedef logic [CW-1:0]           code_t;

  localparam code_t CODE_READY = 3'd0;
  localparam code_t CODE_WB    = 3'd1;
  localparam code_t CODE_MEM   = 3'd2;
  localparam code_t CODE_EX    = 3'd3;

  // One stage of aging, floored at ready.
  function automatic code_t code_dec(input code_t c);
    return (c == CODE_READY) ? CODE_READY : code_t'(c - 3'd1);
  endfunction
endpackage

// File: rtl/scoreboard_cell.sv
// One register's pending-write code: ages each advancing cycle, set by issue, restored by flush.
module scoreboard_cell
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  adv,
  input  logic  set,
  input  logic  restore,
  input  code_t restore_val,
  output code_t code
);
  always_ff @(posedge clk) begin
    if (!rst_n)       code <= CODE_READY;
    else if (adv) begin
      if (set)        code <= CODE_EX;
      else if (restore) code <= restore_val;
      else            code <= code_dec(code);
    end
  end
endmodule

// File: rtl/register_scoreboard.sv
// ID-stage scoreboard feeding register_invalid to the forwarding unit; keeps the EX writer
// record so a branch flush can put back the code the squashed writer overwrote.
module register_scoreboard
  import cpu_pkg::*;
#(
  parameter int NREG = cpu_pkg::NREG,
  parameter int SCW  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           issue_valid,
  input  logic           issue_we,
  input  reg_idx_t       issue_rd,
  input  logic           lock,
  input  logic           freeze,
  input  logic           flush,
  output code_t          register_invalid [NREG-1:0],
  output logic           busy,
  output logic [SCW-1:0] stall_count
);
  logic     adv, fire, do_restore;
  logic     ex_valid;
  reg_idx_t ex_rd;
  code_t    ex_saved;
  code_t    cur_rd_code;

  assign adv        = !freeze;
  assign fire       = issue_valid && issue_we && !lock && !flush;
  assign do_restore = flush && ex_valid;
  assign cur_rd_code = register_invalid[issue_rd];

  for (genvar i = 0; i < NREG; i++) begin : g_cell
    scoreboard_cell u_cell (
      .clk         (clk),
      .rst_n       (rst_n),
      .adv         (adv),
      .set         (fire && (issue_rd == reg_idx_t'(i))),
      .restore     (do_restore && (ex_rd == reg_idx_t'(i))),
      .restore_val (code_dec(ex_saved)),
      .code        (register_invalid[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_rd       <= '0;
      ex_saved    <= CODE_READY;
      stall_count <= '0;
    end else if (adv) begin
      ex_valid <= fire;
      if (fire) begin
        ex_rd    <= issue_rd;
        ex_saved <= code_dec(cur_rd_code);
      end
      if (lock && issue_valid && (stall_count != {SCW{1'b1}}))
        stall_count <= stall_count + SCW'(1);
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NREG; i++) busy |= (register_invalid[i] != CODE_READY);
  end
endmodule
